// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch stage between the PC block and decode.
// Issues one instruction-memory request at a time and queues each response
// with its PC, PC+4 and a misalignment flag in a small FIFO for decode. The PC
// only advances when a request is accepted. A flush drops everything.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), synchronous active-low reset
//   pc_i, pc_en_o       current PC in; PC advance enable out
//   flush_i             redirect: discard queued and in-flight fetches
//   imem_*              req/gnt/rvalid instruction-memory interface
//   id_*                FIFO head presented to decode (valid/ready handshake)
module fetch_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_en_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc4_o,
  output logic            id_misalign_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWaitRsp, StDrain} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [XLEN-1:0] req_pc_q;
  logic            misalign_q;

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] pc4_mem   [DEPTH];
  logic            mis_mem   [DEPTH];

  logic issue_ok, fire, push, pop;

  // Only one request is ever outstanding, so a free slot at issue time is
  // guaranteed to still be free when the response returns.
  assign issue_ok    = (state_q == StIdle) && (count_q < CntW'(DEPTH)) && !flush_i && i_rst_n;
  assign imem_req_o  = issue_ok;
  assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};
  assign fire        = issue_ok && imem_gnt_i;
  assign pc_en_o     = fire;

  assign push       = (state_q == StWaitRsp) && imem_rvalid_i && !flush_i;
  assign id_valid_o = i_rst_n && (count_q != '0);
  assign pop        = id_valid_o && id_ready_i && !flush_i;

  assign id_instr_o    = instr_mem[rd_ptr_q];
  assign id_pc_o       = pc_mem[rd_ptr_q];
  assign id_pc4_o      = pc4_mem[rd_ptr_q];
  assign id_misalign_o = mis_mem[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fire) state_d = StWaitRsp;
      end
      StWaitRsp: begin
        if (imem_rvalid_i)  state_d = StIdle;
        else if (flush_i)   state_d = StDrain;
      end
      StDrain: begin
        // The outstanding response ends the drain even if another flush
        // arrives with it; nothing else is in flight to wait for.
        if (imem_rvalid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      req_pc_q   <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
        pc4_mem[i]   <= '0;
        mis_mem[i]   <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (fire) begin
        req_pc_q   <= pc_i;
        misalign_q <= |pc_i[1:0];
      end
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          instr_mem[wr_ptr_q] <= imem_rdata_i;
          pc_mem[wr_ptr_q]    <= req_pc_q;
          pc4_mem[wr_ptr_q]   <= req_pc_q + XLEN'(4);
          mis_mem[wr_ptr_q]   <= misalign_q;
          wr_ptr_q            <= wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_q <= count_q + CntW'(1);
        else if (pop && !push) count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed testbench for fetch_buffer. Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns later, well away from the next edge.
module tb_fetch_buffer;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;
  logic        id_misalign_o;

  int n_cmp = 0;
  int n_err = 0;

  fetch_buffer #(.DEPTH(2), .XLEN(32)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .pc_i          (pc_i),
    .pc_en_o       (pc_en_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o),
    .id_pc4_o      (id_pc4_o),
    .id_misalign_o (id_misalign_o)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; pc_i = '0; flush_i = 1'b0; imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; id_ready_i = 1'b0;
    tick(); tick();
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_err++;
      $display("FAIL reset_req: got %b exp 0", imem_req_o); end
    n_cmp++; if (pc_en_o !== 1'b0) begin n_err++;
      $display("FAIL reset_pc_en: got %b exp 0", pc_en_o); end
    n_cmp++; if (id_valid_o !== 1'b0) begin n_err++;
      $display("FAIL reset_valid: got %b exp 0", id_valid_o); end
    n_cmp++; if ({id_instr_o, id_pc_o, id_pc4_o, id_misalign_o} !== 97'd0) begin n_err++;
      $display("FAIL reset_head: got %h %h %h %b exp all 0",
               id_instr_o, id_pc_o, id_pc4_o, id_misalign_o); end
    imem_gnt_i = 1'b0;
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    pc_i = 32'h0; imem_gnt_i = 1'b1;
    #1;
    n_cmp++; if ({imem_req_o, pc_en_o} !== 2'b11) begin n_err++;
      $display("FAIL basic_issue: got req=%b pc_en=%b exp 1 1", imem_req_o, pc_en_o); end
    n_cmp++; if (imem_addr_o !== 32'h0) begin n_err++;
      $display("FAIL basic_addr: got %h exp 00000000", imem_addr_o); end
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00500093;
    #1;
    n_cmp++; if ({imem_req_o, pc_en_o} !== 2'b00) begin n_err++;
      $display("FAIL basic_wait: got req=%b pc_en=%b exp 0 0", imem_req_o, pc_en_o); end
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++; if (id_valid_o !== 1'b1) begin n_err++;
      $display("FAIL basic_valid: got %b exp 1", id_valid_o); end
    n_cmp++; if ({id_instr_o, id_pc_o, id_pc4_o} !== {32'h00500093, 32'h0, 32'h4}) begin
      n_err++;
      $display("FAIL basic_head: got %h %h %h exp 00500093 00000000 00000004",
               id_instr_o, id_pc_o, id_pc4_o); end
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    #1;
    n_cmp++; if (id_valid_o !== 1'b0) begin n_err++;
      $display("FAIL basic_pop: got %b exp 0", id_valid_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] data [2];
    data[0] = 32'h11111111; data[1] = 32'h22222222;
    id_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pc_i = 32'(k * 4); imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = data[k];
      tick();
      imem_rvalid_i = 1'b0;
    end
    pc_i = 32'h8; imem_gnt_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if ({imem_req_o, pc_en_o, id_valid_o} !== 3'b001) begin n_err++;
        $display("FAIL full_stall: got req=%b pc_en=%b valid=%b exp 0 0 1",
                 imem_req_o, pc_en_o, id_valid_o); end
      tick();
    end
    imem_gnt_i = 1'b0; id_ready_i = 1'b1;
    #1;
    n_cmp++; if ({id_pc_o, id_instr_o} !== {32'h0, 32'h11111111}) begin n_err++;
      $display("FAIL pop_first: got pc=%h instr=%h exp 00000000 11111111", id_pc_o, id_instr_o); end
    tick();
    #1;
    n_cmp++; if ({id_pc_o, id_instr_o} !== {32'h4, 32'h22222222}) begin n_err++;
      $display("FAIL pop_second: got pc=%h instr=%h exp 00000004 22222222", id_pc_o, id_instr_o); end
    tick();
    id_ready_i = 1'b0; imem_gnt_i = 1'b1;
    #1;
    n_cmp++; if ({id_valid_o, imem_req_o, pc_en_o} !== 3'b011 || imem_addr_o !== 32'h8) begin
      n_err++;
      $display("FAIL resume: got valid=%b req=%b pc_en=%b addr=%h exp 0 1 1 00000008",
               id_valid_o, imem_req_o, pc_en_o, imem_addr_o); end
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h33333333;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++; if ({id_pc_o, id_pc4_o, id_instr_o} !== {32'h8, 32'hC, 32'h33333333}) begin
      n_err++;
      $display("FAIL resume_head: got %h %h %h exp 00000008 0000000c 33333333",
               id_pc_o, id_pc4_o, id_instr_o); end
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
  endtask

  task automatic test_gnt_stall();
    pc_i = 32'h10; imem_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if ({imem_req_o, pc_en_o} !== 2'b10 || imem_addr_o !== 32'h10) begin n_err++;
        $display("FAIL gnt_stall_%0d: got req=%b pc_en=%b addr=%h exp 1 0 00000010",
                 k, imem_req_o, pc_en_o, imem_addr_o); end
      tick();
    end
    imem_gnt_i = 1'b1;
    #1;
    n_cmp++; if (pc_en_o !== 1'b1) begin n_err++;
      $display("FAIL gnt_accept: got pc_en=%b exp 1", pc_en_o); end
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h44444444;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++; if ({id_valid_o, id_pc_o, id_instr_o} !== {1'b1, 32'h10, 32'h44444444}) begin
      n_err++;
      $display("FAIL gnt_head: got %b %h %h exp 1 00000010 44444444",
               id_valid_o, id_pc_o, id_instr_o); end
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    // One queued entry, then a second fetch in flight when the flush hits.
    pc_i = 32'h20; imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h20202020;
    tick();
    imem_rvalid_i = 1'b0; pc_i = 32'h24; imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; flush_i = 1'b1;
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_err++;
      $display("FAIL flush_req: got %b exp 0", imem_req_o); end
    tick();
    flush_i = 1'b0; pc_i = 32'h100; imem_gnt_i = 1'b1;
    #1;
    n_cmp++; if ({id_valid_o, imem_req_o, pc_en_o} !== 3'b000) begin n_err++;
      $display("FAIL flush_drain: got valid=%b req=%b pc_en=%b exp 0 0 0",
               id_valid_o, imem_req_o, pc_en_o); end
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEADBEEF;
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_err++;
      $display("FAIL flush_drain_rsp: got req=%b exp 0", imem_req_o); end
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++; if ({id_valid_o, imem_req_o, pc_en_o} !== 3'b011 || imem_addr_o !== 32'h100) begin
      n_err++;
      $display("FAIL flush_redirect: got valid=%b req=%b pc_en=%b addr=%h exp 0 1 1 00000100",
               id_valid_o, imem_req_o, pc_en_o, imem_addr_o); end
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h55555555;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++; if ({id_pc_o, id_instr_o} !== {32'h100, 32'h55555555}) begin n_err++;
      $display("FAIL flush_head: got %h %h exp 00000100 55555555", id_pc_o, id_instr_o); end
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
  endtask

  task automatic test_arith();
    pc_i = 32'hFFFFFFFC; imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h66666666;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++; if ({id_pc_o, id_pc4_o, id_misalign_o} !== {32'hFFFFFFFC, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL pc4_wrap: got %h %h %b exp fffffffc 00000000 0",
               id_pc_o, id_pc4_o, id_misalign_o); end
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0; pc_i = 32'h6; imem_gnt_i = 1'b1;
    #1;
    n_cmp++; if (imem_addr_o !== 32'h4) begin n_err++;
      $display("FAIL misalign_addr: got %h exp 00000004", imem_addr_o); end
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h77777777;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++; if ({id_pc_o, id_pc4_o, id_misalign_o} !== {32'h6, 32'hA, 1'b1}) begin n_err++;
      $display("FAIL misalign_head: got %h %h %b exp 00000006 0000000a 1",
               id_pc_o, id_pc4_o, id_misalign_o); end
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    pc_i = 32'h40; imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h88888888;
    #1;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin n_err++;
      $display("FAIL rst_mid_req: got req=%b addr=%h exp 1 00000040", imem_req_o, imem_addr_o); end
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++; if (id_valid_o !== 1'b0) begin n_err++;
      $display("FAIL rst_mid_nopush: got valid=%b exp 0", id_valid_o); end
    pc_i = 32'h200; imem_gnt_i = 1'b1;
    #1;
    n_cmp++; if ({imem_req_o, pc_en_o} !== 2'b11 || imem_addr_o !== 32'h200) begin n_err++;
      $display("FAIL rst_mid_issue: got req=%b pc_en=%b addr=%h exp 1 1 00000200",
               imem_req_o, pc_en_o, imem_addr_o); end
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h99999999;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    n_cmp++; if ({id_valid_o, id_pc_o, id_instr_o} !== {1'b1, 32'h200, 32'h99999999}) begin
      n_err++;
      $display("FAIL rst_mid_head: got %b %h %h exp 1 00000200 99999999",
               id_valid_o, id_pc_o, id_instr_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gnt_stall();
    test_flush();
    test_arith();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
